// File: rtl/jk_cmd_pkg.sv
// ============================================================================
// Module      : jk_cmd_pkg
// Description : Shared definitions for the JK command sequencer.
//               - Op codes. They use the same encoding as the flip-flop jk
//                 input, so a command op drives jk without translation.
//               - Sequencer state enum.
//               - jk_next(): next-state function of a JK flip-flop.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package jk_cmd_pkg;

  localparam logic [1:0] JK_HOLD = 2'b00;
  localparam logic [1:0] JK_RST  = 2'b01;
  localparam logic [1:0] JK_SET  = 2'b10;
  localparam logic [1:0] JK_TGL  = 2'b11;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } seq_state_t;

  // Next state of a JK flip-flop with current output q and input code jk.
  function automatic logic jk_next(input logic q, input logic [1:0] jk);
    logic r;
    case (jk)
      JK_HOLD: r = q;
      JK_RST:  r = 1'b0;
      JK_SET:  r = 1'b1;
      default: r = ~q;
    endcase
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/jk_cmd_seq_if.sv
// ============================================================================
// Module      : jk_cmd_seq_if
// Description : Command handshake bundle for jk_cmd_seq.
//   cmd_valid : a command is offered (producer -> sequencer)
//   cmd_ready : sequencer can accept (sequencer -> producer)
//   cmd_op    : 2-bit op, encoded like the flip-flop jk input
//   cmd_cnt   : repeat count in cycles, 0 behaves like 1
//   Modports  : master = command producer, slave = sequencer
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface jk_cmd_seq_if #(
  parameter int CNT_W = 4
);
  import jk_cmd_pkg::*;

  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [CNT_W-1:0] cmd_cnt;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_cnt,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_cnt,
    output cmd_ready
  );

endinterface

`default_nettype wire

// File: rtl/jk_cmd_fifo.sv
// ============================================================================
// Module      : jk_cmd_fifo
// Description : Synchronous FIFO, DEPTH entries of WIDTH bits, first-word
//               fall-through read (o_data shows the head while not empty).
//   clk, rst_n : clock, asynchronous active-low reset (flushes the FIFO)
//   i_push     : write i_data; ignored while o_full
//   i_pop      : drop the head entry; ignored while o_empty
//   o_data     : head entry
//   o_full     : all DEPTH entries in use
//   o_empty    : no entries
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module jk_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 6
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             i_push,
  input  wire logic [WIDTH-1:0] i_data,
  input  wire logic             i_pop,
  output logic      [WIDTH-1:0] o_data,
  output logic                  o_full,
  output logic                  o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  // One extra pointer bit tells full from empty when the indices match.
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_data  = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: the pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

endmodule

`default_nettype wire

// File: rtl/jk_cmd_seq.sv
// ============================================================================
// Module      : jk_cmd_seq
// Description : Command sequencer for a JK flip-flop stage. It buffers
//               {op, count} commands and plays each op on jk for count
//               cycles (0 counts as 1), back-to-back with no gap.
//               Build option JK_CMD_CHECK_EN adds a shadow model of the
//               flip-flop. The model re-syncs to q_fb after reset and
//               raises a sticky mismatch flag when the fed-back q
//               diverges from it.
//   clk, rst_n : clock, asynchronous active-low reset
//   cmd_if     : command handshake (slave side), cmd_ready = !full
//   jk         : registered jk code to the flip-flop
//   busy       : running a command or commands still queued
//   q_fb       : flip-flop q fed back (check builds only)
//   err_clr    : clears mismatch; a new mismatch on the same edge wins
//   q_exp      : shadow-model expected q (0 without JK_CMD_CHECK_EN)
//   mismatch   : sticky divergence flag (0 without JK_CMD_CHECK_EN)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module jk_cmd_seq
  import jk_cmd_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 4
) (
  input  wire logic       clk,
  input  wire logic       rst_n,
  jk_cmd_seq_if.slave     cmd_if,
  output logic      [1:0] jk,
  output logic            busy,
  input  wire logic       q_fb,
  input  wire logic       err_clr,
  output logic            q_exp,
  output logic            mismatch
);

  localparam int FW = 2 + CNT_W;

  seq_state_t       r_state;
  logic [1:0]       r_jk;
  logic [CNT_W-1:0] r_remaining;

  logic [FW-1:0]    w_head;
  logic [1:0]       w_head_op;
  logic [CNT_W-1:0] w_head_cnt;
  logic [CNT_W-1:0] w_load_cnt;
  logic             w_full;
  logic             w_empty;
  logic             w_pop;

  jk_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (FW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (cmd_if.cmd_valid),
    .i_data  ({cmd_if.cmd_op, cmd_if.cmd_cnt}),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign cmd_if.cmd_ready = !w_full;

  assign w_head_op  = w_head[FW-1:CNT_W];
  assign w_head_cnt = w_head[CNT_W-1:0];
  assign w_load_cnt = (w_head_cnt == '0) ? CNT_W'(1) : w_head_cnt;

  // Pop exactly on the edges where the state machine loads a new command:
  // from IDLE, or on the last cycle of the running command.
  assign w_pop = !w_empty &&
                 ((r_state == ST_IDLE) || (r_remaining == CNT_W'(1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_jk        <= JK_HOLD;
      r_remaining <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!w_empty) begin
            r_state     <= ST_RUN;
            r_jk        <= w_head_op;
            r_remaining <= w_load_cnt;
          end
        end
        ST_RUN: begin
          if (r_remaining > CNT_W'(1)) begin
            r_remaining <= r_remaining - CNT_W'(1);
          end else if (!w_empty) begin
            // Reload on the final cycle so consecutive commands abut.
            r_jk        <= w_head_op;
            r_remaining <= w_load_cnt;
          end else begin
            r_state     <= ST_IDLE;
            r_jk        <= JK_HOLD;
            r_remaining <= '0;
          end
        end
      endcase
    end
  end

  assign jk   = r_jk;
  assign busy = (r_state == ST_RUN) || !w_empty;

`ifdef JK_CMD_CHECK_EN
  logic r_q_exp;
  logic r_mismatch;
  logic r_resync;

  // The flip-flop itself has no reset. The first edge after reset copies
  // its present q instead of checking it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q_exp    <= 1'b0;
      r_mismatch <= 1'b0;
      r_resync   <= 1'b1;
    end else begin
      r_resync <= 1'b0;
      if (r_resync) r_q_exp <= q_fb;
      else          r_q_exp <= jk_next(r_q_exp, r_jk);
      if (!r_resync && (q_fb != r_q_exp)) r_mismatch <= 1'b1;
      else if (err_clr)                   r_mismatch <= 1'b0;
    end
  end

  assign q_exp    = r_q_exp;
  assign mismatch = r_mismatch;
`else
  logic w_unused_chk;
  assign w_unused_chk = q_fb ^ err_clr;
  assign q_exp        = 1'b0;
  assign mismatch     = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_jk_cmd_seq.sv
// ============================================================================
// Module      : tb_jk_cmd_seq
// Description : Self-checking bench for jk_cmd_seq. It contains a behavioural
//               JK flip-flop driving q_fb, a directed vector table, hand
//               sequences (full FIFO, reset mid-command, mismatch flag) and
//               random traffic checked against a reference model.
//               Works with JK_CMD_CHECK_EN defined or undefined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_jk_cmd_seq;

  localparam int DEPTH = 4;
  localparam int CNT_W = 4;
`ifdef JK_CMD_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] jk;
  logic       busy;
  logic       q_fb;
  logic       err_clr = 1'b0;
  logic       q_exp;
  logic       mismatch;

  always #5 clk = ~clk;

  jk_cmd_seq_if #(.CNT_W(CNT_W)) cmd_if ();

  jk_cmd_seq #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cmd_if   (cmd_if),
    .jk       (jk),
    .busy     (busy),
    .q_fb     (q_fb),
    .err_clr  (err_clr),
    .q_exp    (q_exp),
    .mismatch (mismatch)
  );

  function automatic logic ff_next(input logic q, input logic [1:0] c);
    if (c == 2'b01) return 1'b0;
    if (c == 2'b10) return 1'b1;
    if (c == 2'b11) return !q;
    return q;
  endfunction

  // Flip-flop under control: no reset. A fault can override its output.
  logic q_ff = 1'b1;
  logic fault_en = 1'b0;
  logic fault_val = 1'b0;
  always @(posedge clk) q_ff <= ff_next(q_ff, jk);
  assign q_fb = fault_en ? fault_val : q_ff;

  // Reference model: a play list of jk codes, one per cycle. Each slot is
  // tagged when it opens a command, so that waiting commands can be counted.
  typedef struct packed {
    logic [1:0] code;
    logic       first;
  } slot_t;

  slot_t      plan[$];
  int         m_inflight;
  logic [1:0] m_jk;
  logic       m_busy, m_ready, m_qexp, m_mis, m_resync;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    plan.delete();
    m_inflight = 0;
    m_jk = 2'b00;
    m_busy = 1'b0;
    m_ready = 1'b1;
    m_qexp = 1'b0;
    m_mis = 1'b0;
    m_resync = 1'b1;
  endtask

  task automatic chk_all();
    chk("jk", jk, m_jk);
    chk("busy", busy, m_busy);
    chk("ready", cmd_if.cmd_ready, m_ready);
    chk("q_exp", q_exp, m_qexp);
    chk("mismatch", mismatch, m_mis);
  endtask

  // One clock: drive inputs, predict, wait for the edge, compare.
  task automatic step(input logic v, input logic [1:0] op, input logic [3:0] cnt,
                      input logic clr, output logic acc);
    logic [1:0] njk;
    logic       issued, nq, nmis;
    slot_t      s;
    int         n;
    cmd_if.cmd_valid = v;
    cmd_if.cmd_op    = op;
    cmd_if.cmd_cnt   = cnt;
    err_clr          = clr;
    #1;
    acc = v && m_ready;
    if (CHK) begin
      nq   = m_resync ? q_fb : ff_next(m_qexp, m_jk);
      nmis = (!m_resync && (q_fb !== m_qexp)) ? 1'b1 : (clr ? 1'b0 : m_mis);
    end else begin
      nq   = 1'b0;
      nmis = 1'b0;
    end
    if (plan.size() > 0) begin
      s = plan.pop_front();
      njk = s.code;
      issued = 1'b1;
      if (s.first) m_inflight--;
    end else begin
      njk = 2'b00;
      issued = 1'b0;
    end
    if (acc) begin
      n = (cnt == 4'd0) ? 1 : int'(cnt);
      for (int i = 0; i < n; i++) plan.push_back('{code: op, first: (i == 0)});
      m_inflight++;
    end
    @(posedge clk);
    #1;
    m_jk     = njk;
    m_busy   = issued || (m_inflight > 0);
    m_ready  = (m_inflight < DEPTH);
    m_qexp   = nq;
    m_mis    = nmis;
    m_resync = 1'b0;
    chk_all();
  endtask

  task automatic idle(input int n);
    logic a;
    for (int i = 0; i < n; i++) step(1'b0, 2'b00, 4'd0, 1'b0, a);
  endtask

  typedef struct {
    logic       v;
    logic [1:0] op;
    logic [3:0] cnt;
    logic [1:0] e_jk;
    logic       e_busy;
    logic       e_ready;
  } vec_t;

  vec_t vt[16];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       acc;
    logic       hv;
    logic [1:0] hop;
    logic [3:0] hcnt;
    int         refused;
    int         tries;

    // Entry i drives the inputs before edge i; expectations hold after edge i.
    vt[0]  = '{1'b1, 2'b10, 4'd3, 2'b00, 1'b1, 1'b1};  // SET x3
    vt[1]  = '{1'b0, 2'b00, 4'd0, 2'b10, 1'b1, 1'b1};
    vt[2]  = '{1'b0, 2'b00, 4'd0, 2'b10, 1'b1, 1'b1};
    vt[3]  = '{1'b0, 2'b00, 4'd0, 2'b10, 1'b1, 1'b1};
    vt[4]  = '{1'b0, 2'b00, 4'd0, 2'b00, 1'b0, 1'b1};
    vt[5]  = '{1'b1, 2'b11, 4'd4, 2'b00, 1'b1, 1'b1};  // TOGGLE x4
    vt[6]  = '{1'b1, 2'b01, 4'd0, 2'b11, 1'b1, 1'b1};  // RESET, count 0
    vt[7]  = '{1'b0, 2'b00, 4'd0, 2'b11, 1'b1, 1'b1};
    vt[8]  = '{1'b0, 2'b00, 4'd0, 2'b11, 1'b1, 1'b1};
    vt[9]  = '{1'b0, 2'b00, 4'd0, 2'b11, 1'b1, 1'b1};
    vt[10] = '{1'b0, 2'b00, 4'd0, 2'b01, 1'b1, 1'b1};
    vt[11] = '{1'b0, 2'b00, 4'd0, 2'b00, 1'b0, 1'b1};
    vt[12] = '{1'b1, 2'b00, 4'd2, 2'b00, 1'b1, 1'b1};  // HOLD x2
    vt[13] = '{1'b0, 2'b00, 4'd0, 2'b00, 1'b1, 1'b1};
    vt[14] = '{1'b0, 2'b00, 4'd0, 2'b00, 1'b1, 1'b1};
    vt[15] = '{1'b0, 2'b00, 4'd0, 2'b00, 1'b0, 1'b1};

    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op    = 2'b00;
    cmd_if.cmd_cnt   = 4'd0;
    model_reset();

    // Reset state
    #12;
    chk_all();
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table
    for (int i = 0; i < 16; i++) begin
      step(vt[i].v, vt[i].op, vt[i].cnt, 1'b0, acc);
      chk("tbl_jk", jk, vt[i].e_jk);
      chk("tbl_busy", busy, vt[i].e_busy);
      chk("tbl_ready", cmd_if.cmd_ready, vt[i].e_ready);
    end

    // Full FIFO behind a 15-cycle command: four more fit, the fifth
    // waits until the edge after the first pop.
    step(1'b1, 2'b10, 4'd15, 1'b0, acc);
    for (int k = 0; k < 5; k++) begin
      refused = 0;
      tries = 0;
      do begin
        step(1'b1, 2'b11, 4'(k + 1), 1'b0, acc);
        if (!acc) refused++;
        tries++;
      end while (!acc && tries < 40);
      chk("full_accept", acc, 1'b1);
      if (k == 3) chk("full_ready", cmd_if.cmd_ready, 1'b0);
      if (k == 4) chk("full_wait", 8'(refused), 8'd12);
    end
    tries = 0;
    while ((busy || plan.size() > 0) && tries < 200) begin
      idle(1);
      tries++;
    end
    chk("drain_busy", busy, 1'b0);

    // Reset in the middle of a TOGGLE x8 with another command queued
    step(1'b1, 2'b11, 4'd8, 1'b0, acc);
    step(1'b1, 2'b10, 4'd2, 1'b0, acc);
    idle(3);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_jk", jk, 2'b00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ready", cmd_if.cmd_ready, 1'b1);
    chk("rst_mis", mismatch, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    if (CHK) chk("resync_q", q_exp, q_fb);
    idle(10);
    chk("post_rst_jk", jk, 2'b00);
    chk("post_rst_mis", mismatch, 1'b0);

    // Mismatch flag: set, hold, clear, and set winning over clear
    step(1'b1, 2'b01, 4'd1, 1'b0, acc);
    idle(3);
    fault_en = 1'b1;
    fault_val = 1'b1;
    idle(1);
    chk("mis_set", mismatch, CHK);
    fault_en = 1'b0;
    idle(2);
    chk("mis_hold", mismatch, CHK);
    step(1'b0, 2'b00, 4'd0, 1'b1, acc);
    chk("mis_clr", mismatch, 1'b0);
    fault_en = 1'b1;
    step(1'b0, 2'b00, 4'd0, 1'b1, acc);
    chk("mis_set_wins", mismatch, CHK);
    chk("mis_qexp", q_exp, 1'b0);
    fault_en = 1'b0;
    step(1'b0, 2'b00, 4'd0, 1'b1, acc);
    chk("mis_clr2", mismatch, 1'b0);

    // Random traffic against the model. A refused offer is held stable
    // until it is taken.
    hv = 1'b0;
    hop = 2'b00;
    hcnt = 4'd0;
    for (int i = 0; i < 400; i++) begin
      if (!hv) begin
        hv   = ($urandom_range(0, 2) == 0);
        hop  = 2'($urandom_range(0, 3));
        hcnt = 4'($urandom_range(0, 5));
      end
      fault_en  = ($urandom_range(0, 31) == 0);
      fault_val = 1'($urandom_range(0, 1));
      step(hv, hop, hcnt, ($urandom_range(0, 15) == 0), acc);
      if (acc) hv = 1'b0;
    end
    fault_en = 1'b0;
    idle(40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/jk_cmd_seq.md
# jk_cmd_seq

Upstream command sequencer for the JK flip-flop stage. It accepts HOLD/RESET/SET/TOGGLE commands, each with a repeat count, over a valid/ready handshake and buffers them in a small FIFO. It plays them out as a registered 2-bit `jk` code, one code per clock, feeding the flip-flop's `jk` input directly. An optional shadow model tracks the expected flip-flop output and flags any divergence from the fed-back `q`.

## Interface
- `DEPTH`, 4: command FIFO entries; power of two, ≥2.
- `CNT_W`, 4: width of the repeat count.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `cmd_valid` input 1: a command is offered.
- `cmd_ready` output 1: FIFO can accept; equals `!full`.
- `cmd_op` input 2: 00 HOLD, 01 RESET, 10 SET, 11 TOGGLE (same encoding as `jk`).
- `cmd_cnt` input CNT_W: number of cycles the op is driven; 0 is treated as 1.
- `jk` output 2: registered code to the flip-flop.
- `busy` output 1: high in RUN or when the FIFO is non-empty.
- `q_fb` input 1: flip-flop `q`, fed back.
- `err_clr` input 1: clears `mismatch`.
- `q_exp` output 1: shadow-model expected `q`.
- `mismatch` output 1: sticky error flag.

## Operation
- Accept: a command is written when `cmd_valid && cmd_ready` at a rising edge. Data must stay stable while `valid` is high and `ready` is low.
- Full FIFO: `cmd_ready` is low. A pop in the same cycle does not admit a push; `ready` rises on the following cycle.
- State machine, two states:
  - IDLE: `jk`=00. On the next edge with the FIFO non-empty, pop the head, load `jk`=op and `remaining`=max(cnt,1), then go to RUN.
  - RUN, `remaining`>1: decrement `remaining` and hold `jk`.
  - RUN, `remaining`==1 with the FIFO non-empty: pop and reload on the same edge, with no bubble.
  - RUN, `remaining`==1 with the FIFO empty: set `jk`=00 and go to IDLE.
- Shadow model: on each edge, `q_exp` takes the next-state of `q_exp` under the current `jk` (00 keep, 01 0, 10 1, 11 invert), matching the flip-flop.
- Resync: the flip-flop has no reset. On the first edge after `rst_n` deasserts, `q_exp` loads `q_fb` and checking is disabled for that cycle. Checking is enabled from then on.
- Check: while checking is enabled, `mismatch` sets on any edge where `q_fb != q_exp` (both sampled before the edge). It stays set until `err_clr` or reset. If `err_clr` and a new mismatch occur on the same edge, set wins.

## Timing
- Reset values (asynchronous, immediate): `jk`=00, state IDLE, FIFO empty, `cmd_ready`=1, `busy`=0, `q_exp`=0, `mismatch`=0, resync pending.
- Latency:
  - Command accepted at edge N into an empty, idle block: `jk`=op from edge N+1.
  - The flip-flop first acts on it at edge N+2.
- A command with count c occupies exactly c cycles of `jk`. Back-to-back commands leave zero gap.
- Reset asserted mid-command: the FIFO is flushed, the command is aborted, and `jk`=00 at once. No partial replay happens after release.
- Count 0 and count 1 behave identically.

## Configuration
- `JK_CMD_CHECK_EN` defined: the shadow model, resync and `mismatch` logic are present as described.
- `JK_CMD_CHECK_EN` undefined:
  - `q_exp` and `mismatch` are tied to 0.
  - `q_fb` and `err_clr` are ignored.
  - No check logic is synthesized.

## Structure
- Package `jk_cmd_pkg` holds:
  - op constants `JK_HOLD`=00, `JK_RST`=01, `JK_SET`=10, `JK_TGL`=11;
  - the state enum (IDLE, RUN);
  - a function `jk_next(q, jk)` returning the flip-flop next state.
- Sub-module `jk_cmd_fifo`: synchronous FIFO, DEPTH × (2+CNT_W), with full/empty flags and asynchronous active-low reset. The top level holds the state machine and the shadow check.

## Test plan
- Single SET, cnt=3, accepted at edge 0 → `jk`=10 for edges 1–3, then 00. `q_fb`, `q_exp` = 1 from edge 2. `busy` falls after edge 4.
- Queue TOGGLE cnt=4, then RESET cnt=1, back-to-back → `jk`=11,11,11,11,01 with no gap. `q` toggles 0→1→0→1→0, then stays 0.
- Push 5 commands with DEPTH=4 while the sequencer is stalled on a cnt=15 command → `cmd_ready`=0 once 4 are queued. The fifth is accepted one cycle after the first pop.
- Assert `rst_n` low during a TOGGLE cnt=8 → `jk`=00 immediately and the FIFO is empty. After release, the first `q_exp` equals `q_fb` and `mismatch` stays 0.
- Force `q_fb`=1 while `q_exp`=0 (check enabled) → `mismatch`=1 the next edge. It holds after the fault is removed, clears on `err_clr`, and sets again if the fault and `err_clr` coincide.
- With `JK_CMD_CHECK_EN` undefined and the same fault as above → `mismatch`=0 and `q_exp`=0 throughout. The `jk` sequence is unchanged.
